// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - program sequencer driving a 4-bit ALU
module alu_op_sequencer #(
    parameter int ADDR_W        = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [11:0]       load_data,
    input  logic              start,
    output logic [7:0]        alu_ui_in,
    output logic [7:0]        alu_uio,
    input  logic [7:0]        alu_uo_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        result,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_REG_WRITE = 4'b1000;
    localparam logic [3:0] OP_JZ        = 4'b1100;
    localparam logic [3:0] OP_JMP       = 4'b1101;
    localparam logic [3:0] OP_NOP       = 4'b1110;
    localparam logic [3:0] OP_HALT      = 4'b1111;
    localparam logic [7:0] STEP_LIMIT   = 8'(MAX_STEPS);
    localparam logic [7:0] WAIT_LAST    = 8'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [11:0]       mem [2**ADDR_W];
    logic [11:0]       ir;
    logic [7:0]        step_cnt;
    logic [7:0]        wait_cnt;
    logic [3:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              start_ok;

    assign op       = ir[11:8];
    assign target   = ADDR_W'(ir[3:0]);
    assign pc_inc   = pc + ADDR_W'(1);
    assign start_ok = !load_en && start;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start_ok) state_nx = S_FETCH;
            S_FETCH:   state_nx = (step_cnt == STEP_LIMIT) ? S_DONE : S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_JZ, OP_JMP, OP_NOP: state_nx = S_FETCH;
                    OP_HALT:               state_nx = S_DONE;
                    default:               state_nx = S_WAIT;
                endcase
            end
            S_WAIT:    if (wait_cnt == WAIT_LAST) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_FETCH;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Program memory is deliberately left out of reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            step_cnt  <= '0;
            wait_cnt  <= '0;
            alu_ui_in <= '0;
            alu_uio   <= '0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        pc       <= '0;
                        step_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (step_cnt == STEP_LIMIT) begin
                        err <= 1'b1;
                    end else begin
                        ir <= mem[pc];
                    end
                end
                S_EXEC: begin
                    step_cnt <= step_cnt + 8'd1;
                    case (op)
                        OP_JZ:   pc <= flags[3] ? target : pc_inc;
                        OP_JMP:  pc <= target;
                        OP_NOP:  pc <= pc_inc;
                        OP_HALT: ;
                        default: begin
                            // ALU drive only changes here, so it holds steady between ops.
                            alu_ui_in <= ir[7:0];
                            alu_uio   <= {4'b0000, op};
                            wait_cnt  <= '0;
                        end
                    endcase
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                S_CAPTURE: begin
                    if (op != OP_REG_WRITE) begin
                        result <= alu_uo_out[3:0];
                        flags  <= alu_uo_out[7:4];
                    end
                    pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
